// File: rtl/hazard_sched_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
// Forward-select encodings, load opcode and the shadow-entry layout.
package hazard_sched_pkg;

    localparam int SH_AW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef struct packed {
        logic             v;
        logic [SH_AW-1:0] rd;
        logic             we;
        logic             ld;
    } shadow_t;

    function automatic logic is_producer(
        input logic             v,
        input logic             we,
        input logic [SH_AW-1:0] rd
    );
        return v && we && (rd != '0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler beside decode: tracks in-flight destinations,
// sequences stall/bubble/flush/freeze and registers EX forward selects.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = SH_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_need,
    input  logic              id_rs2_need,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pipe_freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    shadow_t ex_q, mem_q, wb_q;
    shadow_t ex_n, mem_n, wb_n;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_n, fwd_b_n;
    logic use1, use2, ex_prod, mem_prod, lu;
    logic stall_inc, flush_inc;

    // WB results reach decode through the regfile write-through,
    // so the WB entry and MEM load flag are tracked but never consulted.
    logic unused_shadow;
    assign unused_shadow = ^{wb_q, mem_q.ld};

    assign use1 = id_valid && id_rs1_need && (id_rs1 != '0);
    assign use2 = id_valid && id_rs2_need && (id_rs2 != '0);

    assign ex_prod  = is_producer(ex_q.v, ex_q.we, ex_q.rd);
    assign mem_prod = is_producer(mem_q.v, mem_q.we, mem_q.rd);

    assign lu = ex_prod && ex_q.ld &&
                ((use1 && (id_rs1 == ex_q.rd)) ||
                 (use2 && (id_rs2 == ex_q.rd)));

    function automatic logic [1:0] fwd_sel(
        input logic              use_r,
        input logic [REG_AW-1:0] rs
    );
        if (use_r && ex_prod && (rs == ex_q.rd))
            return FWD_EXMEM;
        else if (use_r && mem_prod && (rs == mem_q.rd))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        ex_n         = ex_q;
        mem_n        = mem_q;
        wb_n         = wb_q;
        fwd_a_n      = fwd_a_q;
        fwd_b_n      = fwd_b_q;
        if (rst) begin
            ex_n = ex_q;
        end else if (!mem_ready) begin
            pipe_freeze = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            wb_n         = mem_q;
            mem_n        = ex_q;
            ex_n         = '0;
            fwd_a_n      = FWD_RF;
            fwd_b_n      = FWD_RF;
        end else if (lu) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            wb_n         = mem_q;
            mem_n        = ex_q;
            ex_n         = '0;
            fwd_a_n      = FWD_RF;
            fwd_b_n      = FWD_RF;
        end else begin
            wb_n    = mem_q;
            mem_n   = ex_q;
            ex_n    = '{v: id_valid, rd: id_rd, we: id_reg_we, ld: id_is_load};
            fwd_a_n = fwd_sel(use1, id_rs1);
            fwd_b_n = fwd_sel(use2, id_rs2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            ex_q    <= ex_n;
            mem_q   <= mem_n;
            wb_q    <= wb_n;
            fwd_a_q <= fwd_a_n;
            fwd_b_q <= fwd_b_n;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched built with 4-bit counters.
// Expected values are hand-derived from the pipeline sequences below.
module tb_hazard_sched;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_rs1_need;
    logic          id_rs2_need;
    logic [4:0]    id_rd;
    logic          id_reg_we;
    logic          id_is_load;
    logic          ex_redirect;
    logic          mem_ready;
    logic          pc_stall;
    logic          if_id_stall;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          pipe_freeze;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [4:0]    ctl;

    int passed = 0;
    int total  = 0;

    hazard_sched #(.CNT_W(CW), .REG_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_need  (id_rs1_need),
        .id_rs2_need  (id_rs2_need),
        .id_rd        (id_rd),
        .id_reg_we    (id_reg_we),
        .id_is_load   (id_is_load),
        .ex_redirect  (ex_redirect),
        .mem_ready    (mem_ready),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .pipe_freeze  (pipe_freeze),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze}
    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic n1,
                         input logic [4:0] rs2, input logic n2,
                         input logic [4:0] rd, input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_need = n1;
        id_rs2      = rs2;
        id_rs2_need = n2;
        id_rd       = rd;
        id_reg_we   = we;
        id_is_load  = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        ex_redirect = 1'b0;
        mem_ready   = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_ctl", 16'(ctl), 16'h0);
        chk("reset_fwd", 16'({fwd_a, fwd_b}), 16'h0);
        chk("reset_cnt", 16'({stall_cnt, flush_cnt}), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // load x5 ; add x6,x5,x1
        drive(1, 2, 1, 0, 0, 5, 1, 1);
        #1 chk("ld_issue_ctl", 16'(ctl), 16'h0);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0);
        #1 chk("lu_ctl", 16'(ctl), 16'b11010);
        tick();
        chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
        #1 chk("lu_once_ctl", 16'(ctl), 16'h0);
        tick();
        chk("lu_fwd_a", 16'(fwd_a), 16'b10);
        chk("lu_fwd_b", 16'(fwd_b), 16'b00);

        // add x5 ; sub x7,x1,x5
        drive(1, 1, 1, 2, 1, 5, 1, 0);
        tick();
        drive(1, 1, 1, 5, 1, 7, 1, 0);
        #1 chk("alu_nostall", 16'(ctl), 16'h0);
        tick();
        chk("exmem_fwd_b", 16'(fwd_b), 16'b01);
        chk("exmem_fwd_a", 16'(fwd_a), 16'b00);

        // add x5 ; add x8,x2,x3 ; sub x7,x1,x5
        drive(1, 1, 1, 2, 1, 5, 1, 0);
        tick();
        drive(1, 2, 1, 3, 1, 8, 1, 0);
        tick();
        chk("indep_fwd_a", 16'(fwd_a), 16'b00);
        drive(1, 1, 1, 5, 1, 7, 1, 0);
        tick();
        chk("memwb_fwd_b", 16'(fwd_b), 16'b10);

        // load x0 ; consumer of x0
        drive(1, 2, 1, 0, 0, 0, 1, 1);
        tick();
        drive(1, 0, 1, 0, 1, 12, 1, 0);
        #1 chk("x0_nostall", 16'(ctl), 16'h0);
        tick();
        chk("x0_fwd", 16'({fwd_a, fwd_b}), 16'h0);

        // redirect beats load-use
        drive(1, 2, 1, 0, 0, 9, 1, 1);
        tick();
        drive(1, 9, 1, 0, 0, 13, 1, 0);
        ex_redirect = 1'b1;
        #1 chk("redir_ctl", 16'(ctl), 16'b00110);
        tick();
        ex_redirect = 1'b0;
        chk("redir_flush_cnt", 16'(flush_cnt), 16'd1);
        chk("redir_stall_cnt", 16'(stall_cnt), 16'd1);
        #1 chk("redir_ex_clear", 16'(ctl), 16'h0);
        tick();
        chk("redir_fwd_a", 16'(fwd_a), 16'b10);

        // freeze over a load-use hazard
        drive(1, 3, 1, 0, 0, 10, 1, 1);
        tick();
        drive(1, 4, 1, 10, 1, 14, 1, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("frz_ctl%0d", i), 16'(ctl), 16'b11001);
            tick();
        end
        chk("frz_stall_held", 16'(stall_cnt), 16'd1);
        mem_ready = 1'b1;
        #1 chk("frz_lu_ctl", 16'(ctl), 16'b11010);
        tick();
        chk("frz_stall_cnt", 16'(stall_cnt), 16'd2);
        #1 chk("frz_after_ctl", 16'(ctl), 16'h0);
        tick();
        chk("frz_fwd_b", 16'(fwd_b), 16'b10);

        // async reset during a frozen load-use hazard
        drive(1, 2, 1, 0, 0, 11, 1, 1);
        tick();
        drive(1, 11, 1, 0, 0, 15, 1, 0);
        #1 chk("rst_pre_ctl", 16'(ctl), 16'b11010);
        mem_ready = 1'b0;
        #1 chk("rst_pre_frz", 16'(ctl), 16'b11001);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 16'(ctl), 16'h0);
        chk("rst_mid_cnt", 16'({stall_cnt, flush_cnt}), 16'h0);
        chk("rst_mid_fwd", 16'({fwd_a, fwd_b}), 16'h0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b1;
        #1 chk("rst_rel_ctl", 16'(ctl), 16'h0);
        tick();
        chk("rst_rel_cnt", 16'(stall_cnt), 16'd0);

        // saturate the stall counter
        for (int i = 0; i < 16; i++) begin
            drive(1, 2, 1, 0, 0, 12, 1, 1);
            tick();
            drive(1, 12, 1, 0, 0, 16, 1, 0);
            tick();
            if (i == 14) chk("sat_15", 16'(stall_cnt), 16'hF);
            if (i == 15) chk("sat_16", 16'(stall_cnt), 16'hF);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline scheduler for the 5-stage core. It sits beside the decode stage and consumes decode's register-use fields (rs1/rs2/rd, need flags, reg_we, load flag).
- Keeps a shadow pipeline of in-flight destinations for EX/MEM/WB and sequences stall, bubble, flush and freeze.
- Issues registered forwarding selects to EX and keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode stage holds a live instruction.
- id_rs1  in  REG_AW  source 1 index.
- id_rs2  in  REG_AW  source 2 index.
- id_rs1_need  in  1  instruction reads rs1.
- id_rs2_need  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination index.
- id_reg_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load (opcode 0000011).
- ex_redirect  in  1  EX resolved a taken branch or jal/jalr this cycle.
- mem_ready  in  1  data memory completes this cycle; 0 freezes the pipe.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  clear the IF/ID register to a bubble.
- id_ex_bubble  out  1  load the ID/EX register with a bubble.
- pipe_freeze  out  1  hold every pipeline register, PC included.
- fwd_a  out  2  EX operand A select: 00 = ID/EX value, 01 = EX/MEM ALU result, 10 = MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of redirects.

Behaviour:
- Shadow entries ex_q, mem_q, wb_q each hold {v, rd, we, ld}.
  - Reset: every field 0.
  - An entry is a producer when v & we & (rd != 0).
- Hazard terms, combinational on current state:
  - use1 = id_valid & id_rs1_need & (id_rs1 != 0); use2 likewise for rs2.
  - lu = ex_q is a producer & ex_q.ld & ((use1 & id_rs1 == ex_q.rd) | (use2 & id_rs2 == ex_q.rd)).
- Priority each cycle is freeze > redirect > load-use > normal.
  - **Freeze** (mem_ready = 0): pipe_freeze = 1, pc_stall = 1, if_id_stall = 1. All shadow state, fwd regs and counters are held. Redirect and lu are ignored this cycle. The EX stage keeps ex_redirect asserted until it is consumed.
  - **Redirect**: if_id_flush = 1, id_ex_bubble = 1, pc_stall = 0. Shift wb_q <= mem_q, mem_q <= ex_q, ex_q <= 0. fwd regs <= 00. flush_cnt += 1.
  - **Load-use** (lu): pc_stall = 1, if_id_stall = 1, id_ex_bubble = 1. Shift with ex_q <= 0. fwd regs <= 00. stall_cnt += 1. The stall lasts exactly one cycle, because the load then sits in mem_q, which forwards.
  - **Normal**: shift. ex_q <= {id_valid, id_rd, id_reg_we, id_is_load}. fwd regs are computed per operand:
    - 01 if ex_q is a producer whose rd matches;
    - else 10 if mem_q is a producer whose rd matches;
    - else 00.
    - The younger producer (ex_q) wins.
- Outputs not asserted by the active case are 0.
- fwd_a/fwd_b are registers, valid during the EX cycle of the instruction they were computed for. Reset value 00.
- Results in WB are covered by the regfile's write-through. No WB-stage hazard is handled here.
- Counters saturate at all-ones and never wrap. Reset value 0.
- lu and redirect in the same cycle: redirect wins and no stall is counted.
- Reset asserted mid-stall or mid-freeze:
  - all state is cleared immediately, and all outputs read 0 while rst is high;
  - the first edge after deassert behaves as the normal case.

Decomposition:
- Shared package holds:
  - FWD_RF / FWD_EXMEM / FWD_MEMWB 2-bit constants;
  - OPC_LOAD = 7'b0000011;
  - the shadow-entry struct {v, rd, we, ld}.
- One sub-module is natural: sat_counter (CNT_W, inc, rst), instantiated twice.

Test Plan:
- Load x5, then add x6,x5,x1 back-to-back → one cycle with pc_stall = if_id_stall = id_ex_bubble = 1. Next ID advance gives fwd_a = 10. stall_cnt = 1.
- add x5 then sub x7,x1,x5 → no stall, fwd_b = 01 in sub's EX cycle. With one independent instruction between them → fwd_b = 10.
- Producer writes x0, consumer reads x0 → no stall, fwd = 00.
- ex_redirect = 1 while a load-use hazard is present → if_id_flush = id_ex_bubble = 1, pc_stall = 0. flush_cnt = 1, stall_cnt unchanged, ex_q invalid next cycle.
- mem_ready = 0 for 3 cycles during a load-use hazard → pipe_freeze = 1 for 3 cycles with state held. Stall fires once, after mem_ready returns to 1.
- Force stall_cnt to all-ones via repeated hazards (CNT_W = 4 build) → the 16th hazard leaves it at 4'hF. rst pulse mid-run → all outputs and counters 0 asynchronously.
